// File: rtl/lc2k_control_fsm.sv
// Multicycle control sequencer for the LC2K core (PC/IR/RF/memory strobes, ALU controls).
// Optional performance counters are enabled by defining LC2K_PERF_CNT_EN.
module lc2k_control_fsm #(
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               alu_eq,
  input  logic               mem_ready,
  output logic [1:0]         pc_sel,
  output logic               pc_write,
  output logic               ir_write,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_addr_sel,
  output logic [1:0]         alu_op,
  output logic               alu_srcb,
  output logic               rf_write,
  output logic               rf_waddr_sel,
  output logic [1:0]         rf_wdata_sel,
`ifdef LC2K_PERF_CNT_EN
  output logic               halted,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt
`else
  output logic               halted
`endif
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_HALTED
  } state_e;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NOR  = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_JALR = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;

  state_e     state_q, state_d;
  logic [2:0] opcode;

  assign opcode = instr[24:22];

  logic unused_instr;
  assign unused_instr = ^{instr[INSTR_W-1:25], instr[21:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Outputs are forced low while rst_n is asserted so an aborted access drops immediately.
  always_comb begin
    state_d      = state_q;
    pc_sel       = 2'b00;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_op       = 2'b00;
    alu_srcb     = 1'b0;
    rf_write     = 1'b0;
    rf_waddr_sel = 1'b0;
    rf_wdata_sel = 2'b00;
    halted       = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          unique case (opcode)
            OP_ADD, OP_NOR, OP_LW, OP_SW: state_d = S_EXEC;
            OP_BEQ, OP_JALR:              state_d = S_BRANCH;
            OP_HALT:                      state_d = S_HALTED;
            default: begin
              pc_write = 1'b1;
              state_d  = S_FETCH;
            end
          endcase
        end
        S_EXEC: begin
          unique case (opcode)
            OP_NOR: begin
              alu_op  = 2'b01;
              state_d = S_WB;
            end
            OP_LW, OP_SW: begin
              alu_srcb = 1'b1;
              state_d  = S_MEM;
            end
            default: state_d = S_WB;
          endcase
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (opcode == OP_SW);
          if (mem_ready) begin
            if (opcode == OP_SW) begin
              pc_write = 1'b1;
              state_d  = S_FETCH;
            end else begin
              state_d  = S_WB;
            end
          end
        end
        S_WB: begin
          rf_write = 1'b1;
          pc_write = 1'b1;
          if (opcode == OP_LW) begin
            rf_waddr_sel = 1'b1;
            rf_wdata_sel = 2'b01;
          end
          state_d = S_FETCH;
        end
        S_BRANCH: begin
          pc_write = 1'b1;
          if (opcode == OP_JALR) begin
            rf_write     = 1'b1;
            rf_waddr_sel = 1'b1;
            rf_wdata_sel = 2'b10;
            pc_sel       = 2'b10;
          end else begin
            alu_op = 2'b10;
            pc_sel = alu_eq ? 2'b01 : 2'b00;
          end
          state_d = S_FETCH;
        end
        S_HALTED: halted = 1'b1;
        default:  state_d = S_FETCH;
      endcase
    end
  end

`ifdef LC2K_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  // The cycle that commits to HALTED is not counted, so the count freezes on halt entry.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (state_q != S_HALTED && state_d != S_HALTED)
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    if (pc_write || (state_q == S_DECODE && state_d == S_HALTED))
      instr_cnt_d = instr_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`else
  logic [31:0] unused_cnt_w;
  assign unused_cnt_w = 32'(CNT_W);
`endif

endmodule
